fb_prog_loader: RTL and testbench

Program-image loader sitting upstream of fb_cpu and in front of the blram port. It accepts a framed word stream over a valid/ready handshake, writes the words into blram, and holds fb_cpu in reset until loading completes. It then releases the CPU and passes the CPU memory port through to blram unchanged.

---
 rtl/fb_prog_loader.sv | 132 +++++++++++++
 tb/tb_fb_prog_loader.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_prog_loader.sv
// Program-image loader: writes a framed valid/ready word stream into blram while
// holding fb_cpu in reset, then hands the RAM port to the CPU.
module fb_prog_loader #(
   parameter int ADDRESS_WIDTH = 6,
   parameter int DATA_WIDTH    = 10,
   parameter int DEPTH         = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_start,
   input  logic                     i_go,
   input  logic                     i_valid,
   input  logic [DATA_WIDTH-1:0]    i_data,
   output logic                     o_ready,
   input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
   input  logic                     cpu_we,
   input  logic [DATA_WIDTH-1:0]    cpu_wdata,
   output logic [ADDRESS_WIDTH-1:0] ram_addr,
   output logic                     ram_we,
   output logic [DATA_WIDTH-1:0]    ram_wdata,
   output logic                     cpu_rst,
   output logic                     o_busy,
   output logic                     o_error,
   output logic [ADDRESS_WIDTH:0]   o_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR_ADDR,
      S_HDR_CNT,
      S_LOAD,
      S_RUN,
      S_ERR
   } state_t;

   localparam logic [DATA_WIDTH:0] DEPTH_N = (DATA_WIDTH + 1)'(DEPTH);

   state_t                   state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] ptr_q, ptr_d;
   logic [ADDRESS_WIDTH:0]   remaining_q, remaining_d;
   logic [ADDRESS_WIDTH:0]   count_q, count_d;
   logic                     error_q, error_d;
   logic                     in_frame;
   logic                     xfer;

   assign in_frame = (state_q == S_HDR_ADDR) || (state_q == S_HDR_CNT) || (state_q == S_LOAD);
   assign o_ready  = in_frame && !rst;
   assign o_busy   = in_frame && !rst;
   assign cpu_rst  = rst || (state_q != S_RUN);
   assign o_error  = error_q;
   assign o_count  = count_q;
   // A restart pulse wins over a word presented in the same cycle.
   assign xfer     = i_valid && o_ready && !i_start;

   // NOTE: every always_comb target gets a default first so no latch is inferred.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      remaining_d = remaining_q;
      count_d     = count_q;
      error_d     = error_q;
      if (i_start) begin
         state_d = S_HDR_ADDR;
         error_d = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: if (i_go) state_d = S_RUN;
            S_HDR_ADDR: if (xfer) begin
               ptr_d   = i_data[ADDRESS_WIDTH-1:0];
               state_d = S_HDR_CNT;
            end
            S_HDR_CNT: if (xfer) begin
               if (i_data == '0) begin
                  count_d = '0;
                  state_d = S_RUN;
               end else if ({1'b0, i_data} > DEPTH_N) begin
                  error_d = 1'b1;
                  state_d = S_ERR;
               end else begin
                  remaining_d = i_data[ADDRESS_WIDTH:0];
                  count_d     = '0;
                  state_d     = S_LOAD;
               end
            end
            S_LOAD: if (xfer) begin
               ptr_d       = ptr_q + 1'b1;
               remaining_d = remaining_q - 1'b1;
               count_d     = count_q + 1'b1;
               if (remaining_q == 1) state_d = S_RUN;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      ram_addr  = '0;
      ram_we    = 1'b0;
      ram_wdata = '0;
      if (!rst) begin
         if (state_q == S_RUN) begin
            ram_addr  = cpu_addr;
            ram_we    = cpu_we;
            ram_wdata = cpu_wdata;
         end else if (state_q == S_LOAD) begin
            ram_addr = ptr_q;
            if (xfer) begin
               ram_we    = 1'b1;
               ram_wdata = i_data;
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         remaining_q <= '0;
         count_q     <= '0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         remaining_q <= remaining_d;
         count_q     <= count_d;
         error_q     <= error_d;
      end
   end

endmodule

// File: tb/tb_fb_prog_loader.sv
// Scoreboard bench for fb_prog_loader: expected RAM writes are queued by the
// stimulus and checked by an independent monitor on every ram_we cycle.
module tb_fb_prog_loader;
   localparam int AW    = 6;
   localparam int DW    = 10;
   localparam int DEPTH = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_start = 1'b0, i_go = 1'b0, i_valid = 1'b0;
   logic [DW-1:0] i_data = '0;
   logic          o_ready;
   logic [AW-1:0] cpu_addr = '0;
   logic          cpu_we = 1'b0;
   logic [DW-1:0] cpu_wdata = '0;
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [DW-1:0] ram_wdata;
   logic          cpu_rst, o_busy, o_error;
   logic [AW:0]   o_count;

   fb_prog_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_go(i_go), .i_valid(i_valid),
      .i_data(i_data), .o_ready(o_ready), .cpu_addr(cpu_addr), .cpu_we(cpu_we),
      .cpu_wdata(cpu_wdata), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
      .cpu_rst(cpu_rst), .o_busy(o_busy), .o_error(o_error), .o_count(o_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   wr_t           exp_q[$];
   wr_t           mon_e;
   logic [DW-1:0] bench_ram [DEPTH] = '{default: '0};
   int            model_ram [DEPTH] = '{default: 0};
   int            n_checks = 0;
   int            n_fail = 0;
   bit            cpu_junk = 1'b0;
   int            max_gap = 0;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // blram behaviour as seen from the loader's RAM port
   always @(posedge clk) if (ram_we === 1'b1) bench_ram[ram_addr] <= ram_wdata;

   always @(negedge clk) begin
      if (ram_we !== 1'b0) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: addr %0d data %0d, none expected (t=%0t)",
                     ram_addr, ram_wdata, $time);
         end else begin
            mon_e = exp_q.pop_front();
            check("write_addr", 32'(ram_addr), 32'(mon_e.addr));
            check("write_data", 32'(ram_wdata), 32'(mon_e.data));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (cpu_junk) begin
         cpu_we    = 1'($urandom_range(0, 1));
         cpu_addr  = AW'($urandom);
         cpu_wdata = DW'($urandom);
      end
   endtask

   task automatic expect_write(input int addr, input int data);
      wr_t e;
      e.addr = addr[AW-1:0];
      e.data = data[DW-1:0];
      exp_q.push_back(e);
      model_ram[addr] = data;
   endtask

   task automatic send_word(input int w, input bit is_data, input int addr);
      int n;
      repeat ($urandom_range(0, max_gap)) begin
         i_valid = 1'b0;
         i_data  = DW'($urandom);
         tick();
      end
      i_valid = 1'b1;
      i_data  = w[DW-1:0];
      n = 0;
      while (o_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      if (o_ready !== 1'b1) begin
         n_checks++;
         n_fail++;
         $display("FAIL ready_timeout: o_ready %b after %0d cycles, required 1", o_ready, n);
      end else if (is_data) begin
         expect_write(addr, w);
      end
      tick();
      i_valid = 1'b0;
   endtask

   task automatic start_frame();
      cpu_we  = 1'b0;
      i_start = 1'b1;
      tick();
      i_start  = 1'b0;
      cpu_junk = 1'b1;
      check("start_busy", 32'(o_busy), 1);
      check("start_ready", 32'(o_ready), 1);
      check("start_cpu_rst", 32'(cpu_rst), 1);
      check("start_error_clr", 32'(o_error), 0);
   endtask

   task automatic frame_body(input int base, input int data[$]);
      send_word(base, 1'b0, 0);
      send_word(data.size(), 1'b0, 0);
      foreach (data[k]) begin
         if (k == data.size() - 1) check("cpu_rst_before_last", 32'(cpu_rst), 1);
         send_word(data[k], 1'b1, (base + k) % DEPTH);
      end
      cpu_junk = 1'b0;
      cpu_we   = 1'b0;
      check("frame_count", 32'(o_count), 32'(data.size()));
      check("frame_cpu_rst", 32'(cpu_rst), 0);
      check("frame_busy", 32'(o_busy), 0);
      check("frame_ready", 32'(o_ready), 0);
   endtask

   task automatic load_frame(input int base, input int data[$]);
      start_frame();
      frame_body(base, data);
   endtask

   task automatic cpu_write(input int a, input int d);
      check("cpu_write_released", 32'(cpu_rst), 0);
      cpu_addr  = a[AW-1:0];
      cpu_wdata = d[DW-1:0];
      cpu_we    = 1'b1;
      expect_write(a, d);
      tick();
      cpu_we = 1'b0;
   endtask

   initial begin
      int data[$];
      int base, n, b;

      cpu_junk = 1'b1;
      repeat (10) begin
         tick();
         check("rst_ready", 32'(o_ready), 0);
         check("rst_cpu_rst", 32'(cpu_rst), 1);
         check("rst_ram_we", 32'(ram_we), 0);
         check("rst_ram_addr", 32'(ram_addr), 0);
      end
      check("rst_busy", 32'(o_busy), 0);
      check("rst_count", 32'(o_count), 0);
      check("rst_error", 32'(o_error), 0);
      check("rst_wdata", 32'(ram_wdata), 0);
      rst = 1'b0;
      tick();
      check("idle_cpu_rst", 32'(cpu_rst), 1);

      // Directed frame with i_valid held high
      max_gap = 0;
      load_frame(50, '{5, 10});
      check("ram50", 32'(bench_ram[50]), 5);
      check("ram51", 32'(bench_ram[51]), 10);
      i_go = 1'b1;
      tick();
      i_go = 1'b0;
      check("go_ignored_in_run", 32'(cpu_rst), 0);
      cpu_write(52, 50);

      // Wrap past the top with gaps between words
      max_gap = 1;
      load_frame(62, '{1, 2, 3, 4});
      check("ram63", 32'(bench_ram[63]), 2);
      check("ram0", 32'(bench_ram[0]), 3);

      // Randomized frames, including single-word and full-depth
      max_gap = 2;
      for (int f = 0; f < 6; f++) begin
         base = $urandom_range(0, DEPTH - 1);
         n = (f == 0) ? 1 : (f == 1) ? DEPTH : $urandom_range(1, DEPTH);
         data.delete();
         repeat (n) data.push_back($urandom_range(0, (1 << DW) - 1));
         load_frame(base, data);
         repeat (3) cpu_write($urandom_range(0, DEPTH - 1), $urandom_range(0, (1 << DW) - 1));
      end

      // Oversized counts are rejected
      for (int e = 0; e < 2; e++) begin
         start_frame();
         send_word(0, 1'b0, 0);
         send_word((e == 0) ? DEPTH + 1 : $urandom_range(DEPTH + 2, (1 << DW) - 1), 1'b0, 0);
         check("err_flag", 32'(o_error), 1);
         check("err_cpu_rst", 32'(cpu_rst), 1);
         check("err_ready", 32'(o_ready), 0);
         check("err_busy", 32'(o_busy), 0);
         i_valid = 1'b1;
         i_data  = DW'($urandom);
         i_go    = 1'b1;
         tick();
         i_go = 1'b0;
         tick();
         i_valid = 1'b0;
         check("err_go_ignored", 32'(cpu_rst), 1);
         check("err_sticky", 32'(o_error), 1);
      end
      max_gap = 0;
      start_frame();
      send_word(0, 1'b0, 0);
      send_word(0, 1'b0, 0);
      cpu_junk = 1'b0;
      cpu_we   = 1'b0;
      check("zero_error", 32'(o_error), 0);
      check("zero_cpu_rst", 32'(cpu_rst), 0);
      check("zero_count", 32'(o_count), 0);

      // Restart mid-frame; the simultaneous word is dropped
      start_frame();
      b = $urandom_range(0, DEPTH - 1);
      send_word(b, 1'b0, 0);
      send_word(5, 1'b0, 0);
      send_word(111, 1'b1, b);
      send_word(222, 1'b1, (b + 1) % DEPTH);
      i_valid = 1'b1;
      i_data  = 10'd333;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      i_valid = 1'b0;
      check("restart_busy", 32'(o_busy), 1);
      frame_body((b + 20) % DEPTH, '{7, 8, 9});

      // Reset after one of three data words
      start_frame();
      b = $urandom_range(0, DEPTH - 1);
      send_word(b, 1'b0, 0);
      send_word(3, 1'b0, 0);
      send_word(444, 1'b1, b);
      rst = 1'b1;
      #1;
      check("midrst_ready_during", 32'(o_ready), 0);
      check("midrst_cpu_rst_during", 32'(cpu_rst), 1);
      tick();
      rst      = 1'b0;
      cpu_junk = 1'b0;
      cpu_we   = 1'b0;
      check("midrst_busy", 32'(o_busy), 0);
      check("midrst_count", 32'(o_count), 0);
      check("midrst_cpu_rst", 32'(cpu_rst), 1);
      check("midrst_retained", 32'(bench_ram[b]), 444);
      i_go = 1'b1;
      tick();
      i_go = 1'b0;
      check("go_release", 32'(cpu_rst), 0);

      // CPU write coincident with i_start still lands; later ones are blocked
      cpu_addr  = 6'd10;
      cpu_wdata = 10'd777;
      cpu_we    = 1'b1;
      expect_write(10, 777);
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      cpu_addr = 6'd11;
      #1;
      check("stop_cpu_rst", 32'(cpu_rst), 1);
      check("stop_ram_we", 32'(ram_we), 0);
      tick();
      cpu_we = 1'b0;

      // IDLE: i_start beats i_go
      rst = 1'b1;
      tick();
      rst     = 1'b0;
      i_start = 1'b1;
      i_go    = 1'b1;
      tick();
      i_start = 1'b0;
      i_go    = 1'b0;
      check("prio_busy", 32'(o_busy), 1);
      check("prio_cpu_rst", 32'(cpu_rst), 1);
      frame_body(30, '{15});

      repeat (3) tick();
      check("queue_drained", 32'(exp_q.size()), 0);
      for (int a = 0; a < DEPTH; a++) check($sformatf("ram_final_%0d", a), 32'(bench_ram[a]), 32'(model_ram[a]));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1);
   end
endmodule
